// File: rtl/axi4_lite_wf_master_if.sv
// Command/response port plus AXI4-Lite master channels for axi4_lite_wf_master.
// The master modport is the DUT's view and the slave modport is the environment's view.
interface axi4_lite_wf_master_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  i_cmd_valid;
  logic                  i_cmd_rw;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [31:0]           i_cmd_wdata;
  logic                  o_cmd_ready;
  logic                  o_rsp_valid;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;
  logic [31:0]           o_txn_cnt;

  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]            M_AXI_AWPROT;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [31:0]           M_AXI_WDATA;
  logic [3:0]            M_AXI_WSTRB;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]            M_AXI_ARPROT;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [31:0]           M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    input  i_cmd_valid, i_cmd_rw, i_cmd_addr, i_cmd_wdata,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_txn_cnt,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output i_cmd_valid, i_cmd_rw, i_cmd_addr, i_cmd_wdata,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_txn_cnt,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_wf_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one write or read burst-free
// transaction, strobes a one-cycle response and counts completed transactions.
module axi4_lite_wf_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 6
) (
  input logic                    M_AXI_ACLK,
  input logic                    M_AXI_ARESET,
  axi4_lite_wf_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != 2'b00);
  endfunction

  state_t                          state_r;
  logic                            cmd_ready_r;
  logic                            awvalid_r;
  logic                            wvalid_r;
  logic                            bready_r;
  logic                            arvalid_r;
  logic                            rready_r;
  logic                            rsp_valid_r;
  logic                            rsp_err_r;
  logic [31:0]                     rsp_rdata_r;
  logic [31:0]                     txn_cnt_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
  logic                            aw_fin_s;
  logic                            w_fin_s;

  // A write channel is finished once its VALID has already dropped or is being accepted now.
  always_comb begin
    aw_fin_s = (!awvalid_r) || bus.M_AXI_AWREADY;
    w_fin_s  = (!wvalid_r)  || bus.M_AXI_WREADY;
  end

  // Transaction FSM with all outputs held in registers.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
      txn_cnt_r   <= 32'd0;
      addr_r      <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      wdata_r     <= {C_M_AXI_DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.i_cmd_valid && cmd_ready_r) begin
            addr_r      <= bus.i_cmd_addr;
            wdata_r     <= bus.i_cmd_wdata;
            cmd_ready_r <= 1'b0;
            if (bus.i_cmd_rw) begin
              arvalid_r <= 1'b1;
              state_r   <= RD_REQ;
            end else begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= WR_REQ;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end

        WR_REQ: begin
          if (awvalid_r && bus.M_AXI_AWREADY) begin
            awvalid_r <= 1'b0;
          end else begin
            awvalid_r <= awvalid_r;
          end
          if (wvalid_r && bus.M_AXI_WREADY) begin
            wvalid_r <= 1'b0;
          end else begin
            wvalid_r <= wvalid_r;
          end
          // Covers AW and W accepted in either order or on the same edge.
          if (aw_fin_s && w_fin_s) begin
            bready_r <= 1'b1;
            state_r  <= WR_RESP;
          end else begin
            state_r  <= WR_REQ;
          end
        end

        WR_RESP: begin
          if (bus.M_AXI_BVALID && bready_r) begin
            bready_r    <= 1'b0;
            rsp_err_r   <= resp_is_err(bus.M_AXI_BRESP);
            rsp_valid_r <= 1'b1;
            txn_cnt_r   <= txn_cnt_r + 32'd1;
            state_r     <= DONE;
          end else begin
            state_r     <= WR_RESP;
          end
        end

        RD_REQ: begin
          if (bus.M_AXI_ARREADY) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_DATA;
          end else begin
            state_r   <= RD_REQ;
          end
        end

        RD_DATA: begin
          if (bus.M_AXI_RVALID && rready_r) begin
            rready_r    <= 1'b0;
            rsp_rdata_r <= bus.M_AXI_RDATA;
            rsp_err_r   <= resp_is_err(bus.M_AXI_RRESP);
            rsp_valid_r <= 1'b1;
            txn_cnt_r   <= txn_cnt_r + 32'd1;
            state_r     <= DONE;
          end else begin
            state_r     <= RD_DATA;
          end
        end

        DONE: begin
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= IDLE;
        end

        default: begin
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready   = cmd_ready_r;
  assign bus.o_rsp_valid   = rsp_valid_r;
  assign bus.o_rsp_rdata   = rsp_rdata_r;
  assign bus.o_rsp_err     = rsp_err_r;
  assign bus.o_txn_cnt     = txn_cnt_r;

  assign bus.M_AXI_AWADDR  = addr_r;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_r;
  assign bus.M_AXI_WDATA   = wdata_r;
  assign bus.M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign bus.M_AXI_WVALID  = wvalid_r;
  assign bus.M_AXI_BREADY  = bready_r;
  assign bus.M_AXI_ARADDR  = addr_r;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid_r;
  assign bus.M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi4_lite_wf_master.sv
// Directed bench for axi4_lite_wf_master: a scripted AXI4-Lite slave plus a response scoreboard.
module tb_axi4_lite_wf_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cnt;
  } rsp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  rsp_t sb[$];
  logic [31:0] exp_cnt;
  logic [31:0] exp_rdata;

  axi4_lite_wf_master_if #(.ADDR_WIDTH(6)) bus ();

  axi4_lite_wf_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(6)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [5:0] addr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    while (bus.o_cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("cmd_ready_before_issue", {31'd0, bus.o_cmd_ready}, 32'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_rw    = rw;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_wdata = wdata;
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr  = 6'h00;
    bus.i_cmd_wdata = 32'h0;
  endtask

  // Sampled in the DONE cycle: strobe, scoreboard entry, then return to idle.
  task automatic check_rsp();
    rsp_t e;
    check("rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
    check("sb_depth", sb.size(), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_rdata", bus.o_rsp_rdata, e.rdata);
      check("rsp_err", {31'd0, bus.o_rsp_err}, {31'd0, e.err});
      check("txn_cnt", bus.o_txn_cnt, e.cnt);
    end
    tick();
    check("rsp_strobe_one_cycle", {31'd0, bus.o_rsp_valid}, 32'd0);
    check("cmd_ready_after_done", {31'd0, bus.o_cmd_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input int aw_lat,
                          input int w_lat, input int b_lat, input logic [1:0] bresp,
                          input bit noise);
    int n;
    sb.push_back('{rdata: exp_rdata, err: (bresp != 2'b00), cnt: exp_cnt + 32'd1});
    exp_cnt = exp_cnt + 32'd1;
    issue(1'b0, addr, data);
    n = (aw_lat > w_lat) ? aw_lat : w_lat;
    for (int k = 0; k <= n; k++) begin
      check("awvalid", {31'd0, bus.M_AXI_AWVALID}, (k <= aw_lat) ? 32'd1 : 32'd0);
      check("wvalid", {31'd0, bus.M_AXI_WVALID}, (k <= w_lat) ? 32'd1 : 32'd0);
      check("bready_early", {31'd0, bus.M_AXI_BREADY}, 32'd0);
      check("awaddr", {26'd0, bus.M_AXI_AWADDR}, {26'd0, addr});
      check("wdata", bus.M_AXI_WDATA, data);
      check("wstrb", {28'd0, bus.M_AXI_WSTRB}, 32'hF);
      check("awprot", {29'd0, bus.M_AXI_AWPROT}, 32'd0);
      bus.M_AXI_AWREADY = (k == aw_lat);
      bus.M_AXI_WREADY  = (k == w_lat);
      if (noise) begin
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_rw    = 1'b1;
        bus.i_cmd_addr  = 6'h3F;
      end
      tick();
    end
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    for (int j = 0; j < b_lat; j++) begin
      check("bready_wait", {31'd0, bus.M_AXI_BREADY}, 32'd1);
      check("aw_w_idle", {30'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID}, 32'd0);
      tick();
    end
    check("bready", {31'd0, bus.M_AXI_BREADY}, 32'd1);
    bus.M_AXI_BVALID = 1'b1;
    bus.M_AXI_BRESP  = bresp;
    bus.i_cmd_valid  = 1'b0;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BRESP  = 2'b00;
    check("bready_drop", {31'd0, bus.M_AXI_BREADY}, 32'd0);
    check_rsp();
  endtask

  task automatic do_read(input logic [5:0] addr, input int ar_lat, input int r_lat,
                         input logic [31:0] rdata, input logic [1:0] rresp);
    exp_rdata = rdata;
    sb.push_back('{rdata: rdata, err: (rresp != 2'b00), cnt: exp_cnt + 32'd1});
    exp_cnt = exp_cnt + 32'd1;
    issue(1'b1, addr, 32'h0);
    for (int k = 0; k <= ar_lat; k++) begin
      check("arvalid_held", {31'd0, bus.M_AXI_ARVALID}, 32'd1);
      check("araddr", {26'd0, bus.M_AXI_ARADDR}, {26'd0, addr});
      check("arprot", {29'd0, bus.M_AXI_ARPROT}, 32'd0);
      check("rready_early", {31'd0, bus.M_AXI_RREADY}, 32'd0);
      bus.M_AXI_ARREADY = (k == ar_lat);
      tick();
    end
    bus.M_AXI_ARREADY = 1'b0;
    check("arvalid_drop", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
    for (int j = 0; j < r_lat; j++) begin
      check("rready_wait", {31'd0, bus.M_AXI_RREADY}, 32'd1);
      tick();
    end
    check("rready", {31'd0, bus.M_AXI_RREADY}, 32'd1);
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RDATA  = rdata;
    bus.M_AXI_RRESP  = rresp;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA  = 32'h0;
    bus.M_AXI_RRESP  = 2'b00;
    check_rsp();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 32'd0;
    exp_rdata = 32'd0;
    rst = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_rw    = 1'b0;
    bus.i_cmd_addr  = 6'h00;
    bus.i_cmd_wdata = 32'h0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RDATA   = 32'h0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RVALID  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'd0, bus.o_rsp_err}, 32'd0);
    check("reset_rdata", bus.o_rsp_rdata, 32'd0);
    check("reset_txn_cnt", bus.o_txn_cnt, 32'd0);
    check("reset_valids", {27'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                           bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 32'd0);
    check("reset_addr", {26'd0, bus.M_AXI_AWADDR}, 32'd0);

    do_write(6'h08, 32'h0000_1234, 0, 0, 0, 2'b00, 1'b0);
    do_read(6'h14, 3, 0, 32'h0000_03E8, 2'b00);
    do_write(6'h20, 32'hDEAD_BEEF, 2, 0, 1, 2'b00, 1'b0);
    do_write(6'h24, 32'h0000_A5A5, 1, 3, 2, 2'b00, 1'b1);
    do_write(6'h0C, 32'h0000_0055, 0, 0, 0, 2'b10, 1'b0);
    do_read(6'h10, 0, 2, 32'hCAFE_F00D, 2'b11);
    do_read(6'h3F, 0, 0, 32'h0000_0001, 2'b00);

    // Abort a write sitting in WR_RESP; the slave's late BVALID must not produce a strobe.
    issue(1'b0, 6'h04, 32'h0000_0077);
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    check("wr_resp_bready", {31'd0, bus.M_AXI_BREADY}, 32'd1);
    rst = 1'b1;
    bus.M_AXI_BVALID = 1'b1;
    #1;
    check("async_reset_valids", {27'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                                 bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 32'd0);
    check("async_reset_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    tick();
    check("reset_no_strobe", {31'd0, bus.o_rsp_valid}, 32'd0);
    bus.M_AXI_BVALID = 1'b0;
    rst = 1'b0;
    check("post_reset_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    check("post_reset_txn_cnt", bus.o_txn_cnt, 32'd0);
    check("post_reset_rdata", bus.o_rsp_rdata, 32'd0);
    exp_cnt   = 32'd0;
    exp_rdata = 32'd0;
    do_read(6'h2C, 1, 1, 32'h0000_600D, 2'b00);

    // Counter wrap from the all-ones value, with busy-time command pulses.
    tick();
    force dut.txn_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.txn_cnt_r;
    #1;
    check("txn_cnt_preload", bus.o_txn_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    do_write(6'h30, 32'h1357_9BDF, 1, 0, 1, 2'b00, 1'b1);
    check("txn_cnt_wrapped", bus.o_txn_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
